// File: rtl/ysyx_23060191_lsu_pkg.sv
// Shared LSU definitions: op codes, FSM state encodings and op-decode helpers.
package ysyx_23060191_lsu_pkg;

  localparam int CPU_WIDTH     = 32;
  localparam int LSU_OPT_WIDTH = 4;

  // Op codes: bit3 = store, bit2 = unsigned (loads), bits[1:0] = size
  localparam logic [LSU_OPT_WIDTH-1:0] LSU_LB  = 4'b0000;
  localparam logic [LSU_OPT_WIDTH-1:0] LSU_LH  = 4'b0001;
  localparam logic [LSU_OPT_WIDTH-1:0] LSU_LW  = 4'b0010;
  localparam logic [LSU_OPT_WIDTH-1:0] LSU_LBU = 4'b0100;
  localparam logic [LSU_OPT_WIDTH-1:0] LSU_LHU = 4'b0101;
  localparam logic [LSU_OPT_WIDTH-1:0] LSU_SB  = 4'b1000;
  localparam logic [LSU_OPT_WIDTH-1:0] LSU_SH  = 4'b1001;
  localparam logic [LSU_OPT_WIDTH-1:0] LSU_SW  = 4'b1010;

  localparam logic [1:0] LSU_SIZE_B = 2'b00;
  localparam logic [1:0] LSU_SIZE_H = 2'b01;
  localparam logic [1:0] LSU_SIZE_W = 2'b10;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'b00,
    LSU_REQ  = 2'b01,
    LSU_WAIT = 2'b10,
    LSU_DONE = 2'b11
  } lsu_state_e;

  // Unknown codes behave exactly like LW
  function automatic logic [LSU_OPT_WIDTH-1:0] lsu_norm_opt(input logic [LSU_OPT_WIDTH-1:0] opt);
    case (opt)
      LSU_LB, LSU_LH, LSU_LW, LSU_LBU, LSU_LHU,
      LSU_SB, LSU_SH, LSU_SW: lsu_norm_opt = opt;
      default:                lsu_norm_opt = LSU_LW;
    endcase
  endfunction

  function automatic logic lsu_is_store(input logic [LSU_OPT_WIDTH-1:0] opt);
    logic [LSU_OPT_WIDTH-1:0] n;
    n = lsu_norm_opt(opt);
    lsu_is_store = n[3];
  endfunction

  function automatic logic lsu_is_unsigned(input logic [LSU_OPT_WIDTH-1:0] opt);
    logic [LSU_OPT_WIDTH-1:0] n;
    n = lsu_norm_opt(opt);
    lsu_is_unsigned = n[2];
  endfunction

  function automatic logic [1:0] lsu_size(input logic [LSU_OPT_WIDTH-1:0] opt);
    logic [LSU_OPT_WIDTH-1:0] n;
    n = lsu_norm_opt(opt);
    lsu_size = n[1:0];
  endfunction

endpackage

// File: rtl/ysyx_23060191_lsu_fmt.sv
// Combinational LSU formatting: store lane shift/strobe, misalign detect,
// and load byte/half extract with sign or zero extension.
module ysyx_23060191_lsu_fmt
  import ysyx_23060191_lsu_pkg::*;
(
  input  logic [1:0]               st_off,
  input  logic [LSU_OPT_WIDTH-1:0] st_opt,
  input  logic [CPU_WIDTH-1:0]     st_wdata,
  input  logic [1:0]               ld_off,
  input  logic [LSU_OPT_WIDTH-1:0] ld_opt,
  input  logic [CPU_WIDTH-1:0]     ld_rdata,
  output logic                     st_wen,
  output logic [CPU_WIDTH-1:0]     st_lane_wdata,
  output logic [3:0]               st_wstrb,
  output logic                     st_misalign,
  output logic [CPU_WIDTH-1:0]     ld_data
);

  logic [1:0]           st_size_s;
  logic [1:0]           ld_size_s;
  logic                 ld_unsigned_s;
  logic [CPU_WIDTH-1:0] ld_shift_s;

  assign st_size_s     = lsu_size(st_opt);
  assign st_wen        = lsu_is_store(st_opt);
  assign ld_size_s     = lsu_size(ld_opt);
  assign ld_unsigned_s = lsu_is_unsigned(ld_opt);
  assign ld_shift_s    = ld_rdata >> {ld_off, 3'b000};

  // Store lane replication and byte strobes; loads drive no lanes
  always_comb begin
    st_lane_wdata = 32'h0000_0000;
    st_wstrb      = 4'b0000;
    if (st_wen) begin
      case (st_size_s)
        LSU_SIZE_B: begin
          st_lane_wdata = {4{st_wdata[7:0]}};
          st_wstrb      = 4'b0001 << st_off;
        end
        LSU_SIZE_H: begin
          st_lane_wdata = {2{st_wdata[15:0]}};
          st_wstrb      = 4'b0011 << st_off;
        end
        LSU_SIZE_W: begin
          st_lane_wdata = st_wdata;
          st_wstrb      = 4'b1111;
        end
        default: begin
          st_lane_wdata = 32'h0000_0000;
          st_wstrb      = 4'b0000;
        end
      endcase
    end else begin
      st_lane_wdata = 32'h0000_0000;
      st_wstrb      = 4'b0000;
    end
  end

  // Natural alignment check for halves and words (loads and stores alike)
  always_comb begin
    st_misalign = 1'b0;
    case (st_size_s)
      LSU_SIZE_H: st_misalign = st_off[0];
      LSU_SIZE_W: st_misalign = (st_off != 2'b00);
      default:    st_misalign = 1'b0;
    endcase
  end

  // Load extract and extend from the raw word
  always_comb begin
    ld_data = 32'h0000_0000;
    case (ld_size_s)
      LSU_SIZE_B: begin
        if (ld_unsigned_s) begin
          ld_data = {24'h00_0000, ld_shift_s[7:0]};
        end else begin
          ld_data = {{24{ld_shift_s[7]}}, ld_shift_s[7:0]};
        end
      end
      LSU_SIZE_H: begin
        if (ld_unsigned_s) begin
          ld_data = {16'h0000, ld_shift_s[15:0]};
        end else begin
          ld_data = {{16{ld_shift_s[15]}}, ld_shift_s[15:0]};
        end
      end
      default: ld_data = ld_rdata;
    endcase
  end

endmodule

// File: rtl/ysyx_23060191_lsu.sv
// RV32 load/store unit: one transaction in flight, IDLE->REQ->WAIT->DONE,
// with every output taken from a register or the state register.
module ysyx_23060191_lsu
  import ysyx_23060191_lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ADDR_W-1:0]        in_addr,
  input  logic [DATA_W-1:0]        in_wdata,
  input  logic [LSU_OPT_WIDTH-1:0] in_opt,
  output logic                     mem_req_valid,
  input  logic                     mem_req_ready,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic                     mem_wen,
  output logic [DATA_W-1:0]        mem_wdata,
  output logic [3:0]               mem_wstrb,
  input  logic                     mem_rsp_valid,
  input  logic [DATA_W-1:0]        mem_rdata,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_rdata,
  output logic                     out_err
);

  lsu_state_e               state_r;
  logic [1:0]               ld_off_r;
  logic [LSU_OPT_WIDTH-1:0] ld_opt_r;
  logic [ADDR_W-1:0]        mem_addr_r;
  logic                     mem_wen_r;
  logic [DATA_W-1:0]        mem_wdata_r;
  logic [3:0]               mem_wstrb_r;
  logic [DATA_W-1:0]        out_rdata_r;
  logic                     out_err_r;

  logic                     st_wen_s;
  logic [DATA_W-1:0]        st_lane_wdata_s;
  logic [3:0]               st_wstrb_s;
  logic                     st_misalign_s;
  logic [DATA_W-1:0]        ld_data_s;

  // Store side is formatted from the incoming op so the request registers
  // load in the accept cycle; load side uses the latched offset/op.
  ysyx_23060191_lsu_fmt u_fmt (
    .st_off        (in_addr[1:0]),
    .st_opt        (in_opt),
    .st_wdata      (in_wdata),
    .ld_off        (ld_off_r),
    .ld_opt        (ld_opt_r),
    .ld_rdata      (mem_rdata),
    .st_wen        (st_wen_s),
    .st_lane_wdata (st_lane_wdata_s),
    .st_wstrb      (st_wstrb_s),
    .st_misalign   (st_misalign_s),
    .ld_data       (ld_data_s)
  );

  // Transaction FSM with latched request and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= LSU_IDLE;
      ld_off_r    <= 2'b00;
      ld_opt_r    <= LSU_LB;
      mem_addr_r  <= '0;
      mem_wen_r   <= 1'b0;
      mem_wdata_r <= '0;
      mem_wstrb_r <= 4'b0000;
      out_rdata_r <= '0;
      out_err_r   <= 1'b0;
    end else begin
      case (state_r)
        LSU_IDLE: begin
          if (in_valid) begin
            ld_off_r    <= in_addr[1:0];
            ld_opt_r    <= in_opt;
            out_rdata_r <= '0;
            if (st_misalign_s) begin
              out_err_r <= 1'b1;
              state_r   <= LSU_DONE;
            end else begin
              mem_addr_r  <= {in_addr[ADDR_W-1:2], 2'b00};
              mem_wen_r   <= st_wen_s;
              mem_wdata_r <= st_lane_wdata_s;
              mem_wstrb_r <= st_wstrb_s;
              out_err_r   <= 1'b0;
              state_r     <= LSU_REQ;
            end
          end else begin
            state_r <= LSU_IDLE;
          end
        end
        LSU_REQ: begin
          if (mem_req_ready) begin
            state_r <= LSU_WAIT;
          end else begin
            state_r <= LSU_REQ;
          end
        end
        LSU_WAIT: begin
          if (mem_rsp_valid) begin
            if (mem_wen_r) begin
              out_rdata_r <= '0;
            end else begin
              out_rdata_r <= ld_data_s;
            end
            state_r <= LSU_DONE;
          end else begin
            state_r <= LSU_WAIT;
          end
        end
        LSU_DONE: begin
          if (out_ready) begin
            state_r <= LSU_IDLE;
          end else begin
            state_r <= LSU_DONE;
          end
        end
        default: state_r <= LSU_IDLE;
      endcase
    end
  end

  assign in_ready      = (state_r == LSU_IDLE);
  assign mem_req_valid = (state_r == LSU_REQ);
  assign out_valid     = (state_r == LSU_DONE);
  assign mem_addr      = mem_addr_r;
  assign mem_wen       = mem_wen_r;
  assign mem_wdata     = mem_wdata_r;
  assign mem_wstrb     = mem_wstrb_r;
  assign out_rdata     = out_rdata_r;
  assign out_err       = out_err_r;

endmodule

// File: tb/tb_ysyx_23060191_lsu.sv
// Directed self-checking bench for ysyx_23060191_lsu.
module tb_ysyx_23060191_lsu;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_addr;
  logic [31:0] in_wdata;
  logic [3:0]  in_opt;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_rsp_valid;
  logic [31:0] mem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_rdata;
  logic        out_err;

  int n_tests;
  int n_fail;
  int hs_cnt;

  ysyx_23060191_lsu #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_addr       (in_addr),
    .in_wdata      (in_wdata),
    .in_opt        (in_opt),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_addr      (mem_addr),
    .mem_wen       (mem_wen),
    .mem_wdata     (mem_wdata),
    .mem_wstrb     (mem_wstrb),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rdata     (mem_rdata),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_rdata     (out_rdata),
    .out_err       (out_err)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count request handshakes seen on the memory port
  always @(posedge clk) begin
    if (mem_req_valid && mem_req_ready) hs_cnt <= hs_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; land 1 ns after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full transaction with optional request/response backpressure
  task automatic do_op(input string tag, input logic [3:0] opt, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] rdata,
                       input logic [31:0] exp_addr, input logic [3:0] exp_wstrb,
                       input logic [31:0] exp_wdata, input logic [31:0] exp_rdata,
                       input logic exp_err, input int req_stall, input int out_stall);
    int hs0;
    hs0 = hs_cnt;
    check_eq({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_opt   = opt;
    in_addr  = addr;
    in_wdata = wdata;
    step();  // now cycle N+1
    in_valid = 1'b0;
    in_addr  = 32'hFFFF_FFFF;
    in_wdata = 32'hFFFF_FFFF;
    if (exp_err) begin
      check_eq({tag, "_err_valid"}, {31'd0, out_valid}, 32'd1);
      check_eq({tag, "_err_flag"}, {31'd0, out_err}, 32'd1);
      check_eq({tag, "_no_req"}, {31'd0, mem_req_valid}, 32'd0);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check_eq({tag, "_err_idle"}, {31'd0, in_ready}, 32'd1);
      check_eq({tag, "_err_no_req2"}, {31'd0, mem_req_valid}, 32'd0);
      check_eq({tag, "_err_hs"}, hs_cnt - hs0, 32'd0);
    end else begin
      for (int i = 0; i <= req_stall; i++) begin
        check_eq({tag, "_req_valid"}, {31'd0, mem_req_valid}, 32'd1);
        check_eq({tag, "_mem_addr"}, mem_addr, exp_addr);
        check_eq({tag, "_wen"}, {31'd0, mem_wen}, {31'd0, opt[3]});
        check_eq({tag, "_wstrb"}, {28'd0, mem_wstrb}, {28'd0, exp_wstrb});
        if (opt[3]) check_eq({tag, "_wdata"}, mem_wdata, exp_wdata);
        check_eq({tag, "_no_out"}, {31'd0, out_valid}, 32'd0);
        if (i == req_stall) mem_req_ready = 1'b1;
        step();
      end
      mem_req_ready = 1'b0;
      // WAIT
      check_eq({tag, "_wait_req"}, {31'd0, mem_req_valid}, 32'd0);
      check_eq({tag, "_wait_out"}, {31'd0, out_valid}, 32'd0);
      mem_rsp_valid = 1'b1;
      mem_rdata     = rdata;
      step();
      mem_rsp_valid = 1'b0;
      mem_rdata     = 32'h5A5A_5A5A;
      for (int i = 0; i <= out_stall; i++) begin
        check_eq({tag, "_out_valid"}, {31'd0, out_valid}, 32'd1);
        check_eq({tag, "_out_rdata"}, out_rdata, exp_rdata);
        check_eq({tag, "_out_err"}, {31'd0, out_err}, 32'd0);
        check_eq({tag, "_done_busy"}, {31'd0, in_ready}, 32'd0);
        if (i == out_stall) out_ready = 1'b1;
        step();
      end
      out_ready = 1'b0;
      check_eq({tag, "_back_idle"}, {31'd0, in_ready}, 32'd1);
      check_eq({tag, "_out_drop"}, {31'd0, out_valid}, 32'd0);
      check_eq({tag, "_hs"}, hs_cnt - hs0, 32'd1);
    end
  endtask

  initial begin
    n_tests       = 0;
    n_fail        = 0;
    hs_cnt        = 0;
    rst_n         = 1'b0;
    in_valid      = 1'b0;
    in_addr       = 32'h0;
    in_wdata      = 32'h0;
    in_opt        = 4'b0000;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rdata     = 32'h0;
    out_ready     = 1'b0;
    step();
    step();

    // Reset values
    check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check_eq("rst_req_valid", {31'd0, mem_req_valid}, 32'd0);
    check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_out_err", {31'd0, out_err}, 32'd0);
    check_eq("rst_out_rdata", out_rdata, 32'h0);
    check_eq("rst_wen", {31'd0, mem_wen}, 32'd0);
    check_eq("rst_wstrb", {28'd0, mem_wstrb}, 32'd0);
    check_eq("rst_addr", mem_addr, 32'h0);
    check_eq("rst_wdata", mem_wdata, 32'h0);
    rst_n = 1'b1;
    step();

    //     tag    opt      addr          wdata         rdata         exp_addr      strb     exp_wdata     exp_rdata   err req out
    do_op("sw",   4'b1010, 32'h8000_0004, 32'hDEAD_BEEF, 32'h1234_5678, 32'h8000_0004, 4'b1111, 32'hDEAD_BEEF, 32'h0,         1'b0, 0, 0);
    do_op("lb",   4'b0000, 32'h8000_0003, 32'h0,         32'h80FF_1234, 32'h8000_0000, 4'b0000, 32'h0,         32'hFFFF_FF80, 1'b0, 0, 0);
    do_op("lbu",  4'b0100, 32'h8000_0003, 32'h0,         32'h80FF_1234, 32'h8000_0000, 4'b0000, 32'h0,         32'h0000_0080, 1'b0, 0, 0);
    do_op("lb0",  4'b0000, 32'h8000_0010, 32'h0,         32'hFFFF_FF7F, 32'h8000_0010, 4'b0000, 32'h0,         32'h0000_007F, 1'b0, 0, 0);
    do_op("lh",   4'b0001, 32'h8000_0002, 32'h0,         32'h9ABC_0000, 32'h8000_0000, 4'b0000, 32'h0,         32'hFFFF_9ABC, 1'b0, 0, 0);
    do_op("lhu",  4'b0101, 32'h8000_0002, 32'h0,         32'h9ABC_0000, 32'h8000_0000, 4'b0000, 32'h0,         32'h0000_9ABC, 1'b0, 0, 0);
    do_op("sb",   4'b1000, 32'h8000_0001, 32'h0000_00A5, 32'h0,         32'h8000_0000, 4'b0010, 32'hA5A5_A5A5, 32'h0,         1'b0, 0, 0);
    do_op("sh",   4'b1001, 32'h8000_0002, 32'h0000_1234, 32'h0,         32'h8000_0000, 4'b1100, 32'h1234_1234, 32'h0,         1'b0, 0, 0);
    do_op("lw_mis", 4'b0010, 32'h8000_0002, 32'h0,       32'h0,         32'h0,         4'b0000, 32'h0,         32'h0,         1'b1, 0, 0);
    do_op("lh_mis", 4'b0001, 32'h8000_0001, 32'h0,       32'h0,         32'h0,         4'b0000, 32'h0,         32'h0,         1'b1, 0, 0);
    do_op("badop", 4'b0111, 32'h8000_000C, 32'h0,        32'h1122_3344, 32'h8000_000C, 4'b0000, 32'h0,         32'h1122_3344, 1'b0, 0, 0);
    do_op("bp_lw", 4'b0010, 32'h8000_0008, 32'h0,        32'hCAFE_F00D, 32'h8000_0008, 4'b0000, 32'h0,         32'hCAFE_F00D, 1'b0, 5, 3);

    // Reset in WAIT, then a stray response after release
    in_valid = 1'b1;
    in_opt   = 4'b0010;
    in_addr  = 32'h8000_0020;
    step();
    in_valid      = 1'b0;
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    check_eq("rw_in_wait", {31'd0, mem_req_valid | out_valid | in_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    check_eq("rw_async_idle", {31'd0, in_ready}, 32'd1);
    check_eq("rw_async_out", {31'd0, out_valid}, 32'd0);
    step();
    rst_n         = 1'b1;
    step();
    mem_rsp_valid = 1'b1;
    mem_rdata     = 32'hBAD0_BAD0;
    step();
    mem_rsp_valid = 1'b0;
    check_eq("rw_idle", {31'd0, in_ready}, 32'd1);
    check_eq("rw_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rw_req_valid", {31'd0, mem_req_valid}, 32'd0);
    check_eq("rw_out_rdata", out_rdata, 32'h0);
    step();
    check_eq("rw_out_valid2", {31'd0, out_valid}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
